// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake between a requester and the PS/2 host transmitter
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  tx_done,
        input  tx_err
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output tx_done,
        output tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter over open-drain ps2c/ps2d
// Optional automatic retry (two retries on NACK/timeout) enabled by PS2_TX_RETRY_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2c_in,
    input  logic          ps2d_in,
    output logic          ps2c_oe,
    output logic          ps2d_oe,
    output logic          busy_inhibit
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // cnt restarts the cycle after a fall and tx_done is registered, so trip two counts
    // early to land exactly TIMEOUT_CYCLES cycles after the fall was seen.
    localparam int TO_LAST = TIMEOUT_CYCLES - 2;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   parity_q, parity_d;
    logic                   nack_q, nack_d;
    logic                   c_oe_q, c_oe_d;
    logic                   d_oe_q, d_oe_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [SYNC_STAGES-1:0] c_sync_q, d_sync_q;
    logic                   c_prev_q;
    logic                   c_s, d_s, fall, fail;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]             retry_q, retry_d;
`endif

    assign c_s  = c_sync_q[SYNC_STAGES-1];
    assign d_s  = d_sync_q[SYNC_STAGES-1];
    assign fall = c_prev_q & ~c_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            nack_q   <= 1'b0;
            c_oe_q   <= 1'b0;
            d_oe_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            c_sync_q <= '1;
            d_sync_q <= '1;
            c_prev_q <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retry_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            nack_q   <= nack_d;
            c_oe_q   <= c_oe_d;
            d_oe_q   <= d_oe_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            c_sync_q <= {c_sync_q[SYNC_STAGES-2:0], ps2c_in};
            d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], ps2d_in};
            c_prev_q <= c_s;
`ifdef PS2_TX_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        nack_d   = nack_q;
        c_oe_d   = c_oe_q;
        d_oe_d   = d_oe_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fail     = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            IDLE: begin
                c_oe_d = 1'b0;
                d_oe_d = 1'b0;
                // the cycle that reports tx_done never accepts, even though tx_ready is already up
                if (tx.tx_valid && ready_q && !done_q) begin
                    shreg_d  = tx.tx_data;
                    parity_d = ~^tx.tx_data;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    c_oe_d   = 1'b1;
                    cnt_d    = '0;
                    nack_d   = 1'b0;
                    state_d  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d  = '0;
`endif
                end
            end
            INHIBIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    d_oe_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                c_oe_d   = 1'b0;
                bitcnt_d = '0;
                cnt_d    = '0;
                state_d  = BITS;
            end
            BITS, ACK, RELEASE: begin
                cnt_d = fall ? '0 : cnt_q + CNT_W'(1);
                if (state_q == RELEASE && c_s && d_s) begin
                    if (nack_q) begin
                        fail = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (!fall && cnt_q == CNT_W'(TO_LAST)) begin
                    fail = 1'b1;
                end else if (fall && state_q == BITS) begin
                    if (bitcnt_q < 4'd8) begin
                        d_oe_d = ~shreg_q[bitcnt_q[2:0]];
                    end else if (bitcnt_q == 4'd8) begin
                        d_oe_d = ~parity_q;
                    end else begin
                        d_oe_d  = 1'b0;
                        state_d = ACK;
                    end
                    bitcnt_d = bitcnt_q + 4'd1;
                end else if (fall && state_q == ACK) begin
                    nack_d  = d_s;
                    state_d = RELEASE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            c_oe_d = 1'b0;
            d_oe_d = 1'b0;
            nack_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q < 2'd2) begin
                retry_d = retry_q + 2'd1;
                c_oe_d  = 1'b1;
                cnt_d   = '0;
                state_d = INHIBIT;
            end else begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
`else
            done_d  = 1'b1;
            err_d   = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
`endif
        end
    end

    assign ps2c_oe      = c_oe_q;
    assign ps2d_oe      = d_oe_q;
    assign busy_inhibit = busy_q;
    assign tx.tx_ready  = ready_q;
    assign tx.tx_done   = done_q;
    assign tx.tx_err    = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a wired-AND PS/2 device model
module tb_ps2_host_tx;
    localparam int INH  = 50;
    localparam int TO   = 200;
    localparam int SYNC = 2;
    localparam int HALF = 8;
`ifdef PS2_TX_RETRY_EN
    localparam int NTRY = 3;
`else
    localparam int NTRY = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe, busy_inhibit;

    ps2_host_tx_if ifc ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx          (ifc),
        .ps2c_in     (ps2c_in),
        .ps2d_in     (ps2d_in),
        .ps2c_oe     (ps2c_oe),
        .ps2d_oe     (ps2d_oe),
        .busy_inhibit(busy_inhibit)
    );

    assign ps2c_in = ~(ps2c_oe | dev_c_low);
    assign ps2d_in = ~(ps2d_oe | dev_d_low);

    always #5 clk = ~clk;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;
    int  done_cnt = 0;
    int  last_done_cyc = 0;
    logic last_err = 1'b0;
    logic rdy_at_done = 1'b0;
    int  fall_cyc = 0;
    bit  exp_bits[$];
    bit  exp_err[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifc.tx_done) begin
            done_cnt      = done_cnt + 1;
            last_err      = ifc.tx_err;
            last_done_cyc = cyc;
            rdy_at_done   = ifc.tx_ready;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic send(input logic [7:0] data, input int attempts, input bit push_err, input bit err);
        exp_bits.delete();
        for (int a = 0; a < attempts; a++) begin
            for (int i = 0; i < 8; i++) exp_bits.push_back(data[i]);
            exp_bits.push_back(~^data);
            exp_bits.push_back(1'b1);
        end
        if (push_err) exp_err.push_back(err);
        @(negedge clk);
        ifc.tx_valid = 1'b1;
        ifc.tx_data  = data;
        @(negedge clk);
        ifc.tx_valid = 1'b0;
        check("ready_drop", ifc.tx_ready, 1'b0);
        check("busy_set", busy_inhibit, 1'b1);
    endtask

    // one host request seen from the device: measure inhibit/request, then clock pulses
    task automatic dev_frame(input bit ack, input int pulses);
        int n;
        n = 0;
        while (!(ps2c_oe && !ps2d_oe) && n < 2000) begin n++; @(negedge clk); end
        check("inhibit_seen", (n < 2000), 1'b1);
        n = 0;
        while (ps2c_oe && !ps2d_oe && n < 2000) begin n++; @(negedge clk); end
        check("inhibit_len", n, INH);
        n = 0;
        while (ps2c_oe && ps2d_oe && n < 10) begin n++; @(negedge clk); end
        check("req_len", n, 1);
        check("start_bit", {ps2c_oe, ps2d_oe}, 2'b01);
        for (int i = 0; i < pulses; i++) begin
            if (i == 10) dev_d_low = ack;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b1;
            fall_cyc  = cyc;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            if (i < 10) begin
                if (exp_bits.size() == 0) check("sb_underflow", 1, 0);
                else check("bit", ps2d_in, exp_bits.pop_front());
            end
        end
        repeat (HALF) @(negedge clk);
        dev_d_low = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin n++; @(negedge clk); end
        check("done_seen", (done_cnt != d0), 1'b1);
        if (exp_err.size() == 0) check("sb_err_underflow", 1, 0);
        else check("done_err", last_err, exp_err.pop_front());
        check("ready_at_done", rdy_at_done, 1'b1);
        repeat (20) @(negedge clk);
        check("done_once", done_cnt - d0, 1);
        check("lines_released", {ps2c_oe, ps2d_oe}, 2'b00);
        check("busy_clear", busy_inhibit, 1'b0);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        ifc.tx_valid = 1'b0;
        ifc.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ifc.tx_ready, 1'b1);
        check("rst_oe", {ps2c_oe, ps2d_oe}, 2'b00);
        check("rst_busy", busy_inhibit, 1'b0);
        check("rst_done", {ifc.tx_done, ifc.tx_err}, 2'b00);

        // ACKed transfers with different parities
        d0 = done_cnt;
        send(8'hED, 1, 1'b1, 1'b0);
        dev_frame(1'b1, 11);
        wait_done(d0);

        d0 = done_cnt;
        send(8'hF4, 1, 1'b1, 1'b0);
        dev_frame(1'b1, 11);
        wait_done(d0);

        // device leaves data high in the ACK slot
        d0 = done_cnt;
        send(8'h3C, NTRY, 1'b1, 1'b1);
        for (int t = 0; t < NTRY; t++) dev_frame(1'b0, 11);
        wait_done(d0);

        // device stops clocking after bit 3
        d0 = done_cnt;
        send(8'h5A, NTRY, 1'b1, 1'b1);
        for (int t = 0; t < NTRY; t++) dev_frame(1'b1, 4);
        wait_done(d0);
        check("timeout_cycle", last_done_cyc, fall_cyc + SYNC + TO);

        // reset in the middle of BITS
        d0 = done_cnt;
        send(8'hA5, 1, 1'b0, 1'b0);
        dev_frame(1'b1, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_oe", {ps2c_oe, ps2d_oe}, 2'b00);
        check("midrst_ready", ifc.tx_ready, 1'b1);
        check("midrst_busy", busy_inhibit, 1'b0);
        repeat (TO + 50) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);

        // 0xFF: NACK twice then ACK with retry, else a single NACK failure
        d0 = done_cnt;
`ifdef PS2_TX_RETRY_EN
        send(8'hFF, 3, 1'b1, 1'b0);
        dev_frame(1'b0, 11);
        dev_frame(1'b0, 11);
        dev_frame(1'b1, 11);
`else
        send(8'hFF, 1, 1'b1, 1'b1);
        dev_frame(1'b0, 11);
`endif
        wait_done(d0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED for set-LEDs or 0xFF for reset. It is the opposite direction of the keyboard receiver that feeds key2state. It shares the ps2c/ps2d lines through open-drain enables and runs in the main `clk` domain.

Parameters:
INHIBIT_CYCLES, 12000, clk cycles the host holds ps2c low before the start bit (120 us at 100 MHz).
TIMEOUT_CYCLES, 2000000, max clk cycles allowed between device clock falling edges, or while waiting for bus release (20 ms).
SYNC_STAGES, 2, synchronizer depth on ps2c_in/ps2d_in (allowed values 2 or 3).

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous reset, active-high
tx_valid  in  1  request to send tx_data
tx_data  in  8  command byte
tx_ready  out  1  high when idle; a byte is accepted when tx_valid & tx_ready
ps2c_in  in  1  sampled PS/2 clock line (asynchronous)
ps2d_in  in  1  sampled PS/2 data line (asynchronous)
ps2c_oe  out  1  1 = pull ps2c low; 0 = release the line
ps2d_oe  out  1  1 = pull ps2d low; 0 = release the line
tx_done  out  1  one-cycle pulse when a transfer ends
tx_err  out  1  valid with tx_done: 1 = NACK or timeout
busy_inhibit  out  1  high from acceptance to completion; tells the receiver to ignore the line

Behaviour:
- Reset values, applied on the clk edge with rst=1 regardless of state:
  - tx_ready=1; ps2c_oe=0; ps2d_oe=0; tx_done=0; tx_err=0; busy_inhibit=0.
  - Counters are cleared. FSM goes to IDLE.
  - Reset in the middle of a frame releases both lines on the next cycle.
- Input conditioning:
  - ps2c_in and ps2d_in pass through SYNC_STAGES flops.
  - fall = synchronized clock was 1 last cycle and is 0 now.
- Acceptance:
  - In IDLE with tx_valid=1, the byte is latched into shreg.
  - parity = ~^tx_data (odd parity).
  - tx_ready drops on the next cycle. tx_valid is ignored while tx_ready=0.
- FSM states:
  - IDLE: lines released. On acceptance go to INHIBIT and clear cnt.
  - INHIBIT: ps2c_oe=1. After INHIBIT_CYCLES cycles set ps2d_oe=1 (start bit) and go to REQ.
  - REQ: hold both lines low for exactly 1 cycle. Then set ps2c_oe=0 with ps2d_oe still 1, and go to BITS with bitcnt=0.
  - BITS, on each fall:
    - bitcnt 0..7: ps2d_oe = ~shreg[bitcnt] (LSB first).
    - bitcnt 8: ps2d_oe = ~parity.
    - bitcnt 9: ps2d_oe=0 (stop bit, line released).
    - bitcnt increments on each fall. The data change takes effect the cycle after fall.
  - ACK: reached on the fall after the stop bit (bitcnt 10). Sample the synchronized data line on that fall: 0 = ACK, 1 = NACK. Go to RELEASE.
  - RELEASE: wait for synchronized clock=1 and data=1. Then pulse tx_done with tx_err = NACK; go to IDLE.
- Timeout:
  - cnt resets on every fall.
  - In BITS/ACK/RELEASE, cnt reaching TIMEOUT_CYCLES releases both lines, pulses tx_done with tx_err=1, and returns to IDLE.
- Idle and done:
  - tx_ready returns to 1 in the same cycle as the tx_done pulse.
  - A new tx_valid in that same cycle is not accepted; acceptance happens on the next cycle.
- ps2c_oe and ps2d_oe are registered outputs, glitch-free.

Optional Feature:
PS2_TX_RETRY_EN
- Defined: on NACK or timeout the block re-enters INHIBIT with the same byte, up to 2 retries.
  - tx_done pulses only once: on success (tx_err=0), or after the third failure (tx_err=1).
  - busy_inhibit stays high throughout the retries.
- Undefined: no retry. The first failure reports tx_err=1.

Test Plan:
1. tx_data=0xED with a device model ACKing → ps2c held low for exactly INHIBIT_CYCLES (sim value 50), then 1 cycle with both low. Bits seen on device rising edges: 1,0,1,1,0,1,1,1, parity 1, stop 1. tx_done=1, tx_err=0.
2. tx_data=0xF4 → parity bit 0; data bits 0,0,1,0,1,1,1,1. Completion with tx_err=0.
3. Device leaves data high in the ACK slot → tx_done with tx_err=1. Both oe low afterwards.
4. Device stops clocking after bit 3 (TIMEOUT_CYCLES=200 in sim) → tx_done with tx_err=1 exactly 200 cycles after the last fall. Lines released.
5. rst=1 asserted during BITS → next cycle ps2c_oe=0, ps2d_oe=0, tx_ready=1. No tx_done pulse.
6. With PS2_TX_RETRY_EN, device NACKs twice then ACKs for 0xFF → three INHIBIT phases, a single tx_done with tx_err=0. Without the macro → a single tx_done with tx_err=1 after the first NACK.
